// File: rtl/vram_write_scheduler.sv
// Host-to-PPU table write buffer: queues Avalon writes and commits them to the
// attribute/color/pattern/sprite tables only while the PPU is not fetching.
module vram_write_scheduler #(
    parameter int DEPTH   = 16,
    parameter int VACTIVE = 480,
    parameter int VTOTAL  = 525,
    parameter int HTOTAL  = 1600
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     chipselect,
    input  logic                     write,
    input  logic [15:0]              address,
    input  logic [31:0]              writedata,
    output logic                     waitrequest,
    input  logic [10:0]              hcount,
    input  logic [9:0]               vcount,
    input  logic                     bypass,
    output logic [3:0]               mem_we,
    output logic [15:0]              mem_addr,
    output logic [31:0]              mem_data,
    output logic                     pending,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_tick
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [9:0]    V_FIRST    = 10'(VACTIVE);
    // Line VTOTAL-1 is kept closed: the PPU prefetches line 0 during its hblank.
    localparam logic [9:0]    V_LAST     = 10'(VTOTAL - 2);
    localparam logic [9:0]    V_END      = 10'(VTOTAL - 1);
    localparam logic [10:0]   H_END      = 11'(HTOTAL - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t         state, state_next;
    logic [47:0]    fifo [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [47:0]    head;
    logic           full, push, pop, drain_ok;

    function automatic logic [3:0] table_we(input logic [3:0] sel);
        logic [3:0] we;
        case (sel)
            4'd0:    we = 4'b0001;
            4'd1:    we = 4'b0010;
            4'd2:    we = 4'b0100;
            default: we = 4'b1000;
        endcase
        return we;
    endfunction

    assign full        = (level == FULL_LEVEL);
    assign waitrequest = full;
    assign pending     = (level != '0);
    assign push        = chipselect & write & ~full;
    assign drain_ok    = bypass | ((vcount >= V_FIRST) & (vcount <= V_LAST));
    assign head        = fifo[rd_ptr];
    assign frame_tick  = ~reset & (hcount == H_END) & (vcount == V_END);

    // Pop is decided in the same cycle the window and a pending entry coincide,
    // so a freshly queued entry commits one edge after it becomes visible.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (drain_ok & pending) begin
                    pop        = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_ok & pending) pop = 1'b1;
                else                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= {address, writedata};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Commit stage: address/data hold their last committed value between pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we   <= '0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (pop) begin
            mem_we   <= table_we(head[47:44]);
            mem_addr <= head[47:32];
            mem_data <= head[31:0];
        end else begin
            mem_we   <= '0;
        end
    end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Bench for vram_write_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the buffered table writes.
module tb_vram_write_scheduler;

    localparam int DEPTH   = 16;
    localparam int VACTIVE = 480;
    localparam int VTOTAL  = 525;
    localparam int HTOTAL  = 1600;

    logic clk = 1'b0;
    logic reset, chipselect, write, waitrequest, bypass, pending, frame_tick;
    logic [15:0] address, mem_addr;
    logic [31:0] writedata, mem_data;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [3:0]  mem_we;
    logic [$clog2(DEPTH):0] level;

    int checks = 0;
    int failures = 0;
    bit free_run = 1'b0;

    logic [47:0] model_q[$];
    logic [3:0]  exp_we   = '0;
    logic [15:0] exp_addr = '0;
    logic [31:0] exp_data = '0;

    logic [15:0] addrs [17];
    logic [31:0] datas [17];

    always #5 clk = ~clk;

    vram_write_scheduler #(
        .DEPTH(DEPTH), .VACTIVE(VACTIVE), .VTOTAL(VTOTAL), .HTOTAL(HTOTAL)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .waitrequest(waitrequest),
        .hcount(hcount), .vcount(vcount), .bypass(bypass), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_data(mem_data), .pending(pending),
        .level(level), .frame_tick(frame_tick)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Table number is the top nibble; 0..2 are one-hot, everything else is sprite.
    function automatic logic [3:0] expected_we(input logic [15:0] a);
        int tbl;
        tbl = int'(a >> 12);
        return (tbl < 3) ? 4'(1 << tbl) : 4'b1000;
    endfunction

    function automatic bit window(input logic [9:0] v, input logic b);
        return b || (int'(v) >= VACTIVE && int'(v) <= VTOTAL - 2);
    endfunction

    always @(posedge clk) begin
        logic [47:0] e;
        bit do_pop, do_push;
        if (reset) begin
            model_q.delete();
            exp_we = '0; exp_addr = '0; exp_data = '0;
        end else begin
            do_pop  = window(vcount, bypass) && model_q.size() > 0;
            do_push = chipselect && write && model_q.size() < DEPTH;
            if (do_pop) begin
                e = model_q.pop_front();
                exp_we   = expected_we(e[47:32]);
                exp_addr = e[47:32];
                exp_data = e[31:0];
            end else begin
                exp_we = '0;
            end
            if (do_push) model_q.push_back({address, writedata});
        end
        #1;
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_data", mem_data, exp_data);
        chk("level", level, model_q.size());
        chk("pending", pending, model_q.size() != 0);
        chk("waitrequest", waitrequest, model_q.size() == DEPTH);
        chk("frame_tick", frame_tick,
            !reset && int'(hcount) == HTOTAL - 1 && int'(vcount) == VTOTAL - 1);
    end

    task automatic tick();
        @(negedge clk);
        if (free_run) begin
            if (int'(hcount) == HTOTAL - 1) begin
                hcount = '0;
                vcount = (int'(vcount) == VTOTAL - 1) ? 10'd0 : vcount + 10'd1;
            end else begin
                hcount = hcount + 11'd1;
            end
        end
    endtask

    task automatic host_write(input logic [15:0] a, input logic [31:0] d);
        logic w;
        int n;
        n = 0;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        do begin
            w = waitrequest;
            tick();
            n++;
        end while (w && n < 300);
        if (w) chk("accept_timeout", 1, 0);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (pending && n < 100) begin
            tick();
            n++;
        end
        chk("drain_done", pending, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pops, ft, run, n;
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
        bypass = 1'b0;
        hcount = 11'(HTOTAL - 1); vcount = 10'(VTOTAL - 1);
        repeat (2) @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_waitrequest", waitrequest, 0);
        chk("rst_pending", pending, 0);
        chk("rst_level", level, 0);
        chk("rst_frame_tick", frame_tick, 0);
        reset = 1'b0; hcount = '0; vcount = 10'd100;
        repeat (2) tick();

        // Writes queued outside the window wait for line 480.
        host_write(16'h2005, 32'h0000_0A03);
        host_write(16'h1002, 32'h00FF_0000);
        repeat (5) tick();
        chk("closed_level", level, 2);
        chk("closed_we", mem_we, 0);
        vcount = 10'd480;
        tick();
        chk("open_we0", mem_we, 4'b0100);
        chk("open_addr0", mem_addr, 16'h2005);
        chk("open_data0", mem_data, 32'h0000_0A03);
        tick();
        chk("open_we1", mem_we, 4'b0010);
        chk("open_addr1", mem_addr, 16'h1002);
        tick();
        chk("open_empty", pending, 0);

        // Back-pressure: 16 fill the FIFO, the 17th is held.
        vcount = 10'd10;
        tick();
        for (int i = 0; i < 17; i++) begin
            addrs[i] = {4'(i % 5), 12'(i * 7)};
            datas[i] = $urandom;
        end
        for (int i = 0; i < 16; i++) host_write(addrs[i], datas[i]);
        chipselect = 1'b1; write = 1'b1; address = addrs[16]; writedata = datas[16];
        repeat (3) tick();
        chk("full_wait", waitrequest, 1);
        chk("full_level", level, 16);
        vcount = 10'd480;
        tick();
        chk("full_first_we", mem_we, expected_we(addrs[0]));
        chk("full_first_addr", mem_addr, addrs[0]);
        chk("full_wait_drop", waitrequest, 0);
        host_write(addrs[16], datas[16]);
        wait_drain();

        // Window edge: three pops at the end of line 523, the fourth waits a frame.
        vcount = 10'd10;
        tick();
        for (int i = 0; i < 4; i++) host_write(addrs[i], datas[i]);
        hcount = 11'd1597; vcount = 10'd523; free_run = 1'b1;
        pops = 0; ft = 0;
        for (n = 0; n < 2000; n++) begin
            tick();
            if (mem_we != 0) pops++;
            if (frame_tick) ft++;
            if (vcount == 10'd0 && hcount == 11'd100) break;
        end
        chk("edge_pops", pops, 3);
        chk("edge_frame_tick", ft, 1);
        chk("edge_level", level, 1);
        hcount = 11'd1595; vcount = 10'd479;
        for (n = 0; n < 20; n++) begin
            tick();
            if (vcount == 10'd480 && hcount == 11'd0) break;
        end
        chk("edge_pre480_we", mem_we, 0);
        chk("edge_pre480_level", level, 1);
        tick();
        chk("edge_480_we", mem_we, expected_we(addrs[3]));
        chk("edge_480_addr", mem_addr, addrs[3]);
        chk("edge_480_level", level, 0);
        free_run = 1'b0;

        // Bypass drains during active video.
        vcount = 10'd200; hcount = 11'd0; bypass = 1'b1;
        tick();
        host_write(16'h3010, 32'hDEAD_BEEF);
        tick();
        chk("bypass_we", mem_we, 4'b1000);
        chk("bypass_addr", mem_addr, 16'h3010);
        chk("bypass_data", mem_data, 32'hDEAD_BEEF);
        bypass = 1'b0;
        tick();

        // Streaming: push and pop every cycle, occupancy stays at one.
        vcount = 10'd480;
        tick();
        run = 0;
        for (int i = 0; i < 8; i++) begin
            host_write({4'(i % 4), 12'(i)}, $urandom);
            chk("stream_level", level, 1);
            if (mem_we != 0) run++;
        end
        tick();
        if (mem_we != 0) run++;
        tick();
        chk("stream_idle", mem_we, 0);
        chk("stream_run", run, 8);

        // Reset in the middle of a drain.
        vcount = 10'd10;
        tick();
        for (int i = 0; i < 5; i++) host_write(addrs[i], datas[i]);
        vcount = 10'd481;
        tick();
        tick();
        chk("mid_second_addr", mem_addr, addrs[1]);
        reset = 1'b1;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_pending", pending, 0);
        tick();
        reset = 1'b0;
        pops = 0;
        repeat (10) begin
            tick();
            if (mem_we != 0) pops++;
        end
        chk("mid_rst_no_writes", pops, 0);

        // Random traffic across window states.
        for (int i = 0; i < 3000; i++) begin
            tick();
            chipselect = 1'($urandom % 2);
            write      = 1'(($urandom % 4) != 0);
            address    = 16'($urandom);
            writedata  = $urandom;
            bypass     = 1'(($urandom % 8) == 0);
            case ($urandom % 6)
                0: vcount = 10'd100;
                1: vcount = 10'd479;
                2: vcount = 10'd480;
                3: vcount = 10'd500;
                4: vcount = 10'd523;
                default: vcount = 10'd524;
            endcase
            hcount = (($urandom % 4) == 0) ? 11'(HTOTAL - 1) : 11'($urandom % HTOTAL);
        end
        tick();
        chipselect = 1'b0; write = 1'b0; bypass = 1'b1;
        tick();
        wait_drain();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
